// File: rtl/titan_pkg.sv
// ----------------------------------------------------------------------------
// titan_pkg
//   Shared definitions for the Titan RV32I pipeline decode stage:
//   - RV32I major opcode constants (instr[6:0])
//   - the 4-bit op-class enum carried down the pipe to EX
//   - the ID/EX control-bit bundle, which is cleared as a unit
//     for bubbles, flushes and non-valid slots
// ----------------------------------------------------------------------------
package titan_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // OP_NONE is the class of bubbles, reset state and illegal encodings,
  // so an all-zero control bundle is always a harmless slot.
  typedef enum logic [3:0] {
    OP_NONE   = 4'd0,
    OP_LUI    = 4'd1,
    OP_AUIPC  = 4'd2,
    OP_JAL    = 4'd3,
    OP_JALR   = 4'd4,
    OP_BRANCH = 4'd5,
    OP_LOAD   = 4'd6,
    OP_STORE  = 4'd7,
    OP_OPIMM  = 4'd8,
    OP_OP     = 4'd9,
    OP_FENCE  = 4'd10,
    OP_SYSTEM = 4'd11
  } op_class_e;

  typedef struct packed {
    logic      valid;
    op_class_e op;
    logic      mem_read;
    logic      mem_write;
    logic      reg_write;
    logic      exc_illegal;
    logic      exc_addr;
  } idex_ctrl_t;

endpackage

// File: rtl/id_regfile.sv
// ----------------------------------------------------------------------------
// id_regfile
//   32 x XLEN integer register file with two combinational read ports and one
//   write port committed on the clock edge. x0 reads as zero and ignores
//   writes. A write in the same cycle as a read of the same register is
//   forwarded to the read port, so ID sees the value WB is retiring now.
//   The whole array clears on a synchronous reset.
//
//   clk_i, rst_i          clock, synchronous active-high reset
//   we_i, waddr_i, wdata_i write port (from WB)
//   raddr1_i, raddr2_i    read addresses (rs1, rs2)
//   rdata1_o, rdata2_o    read data, bypassed
// ----------------------------------------------------------------------------
module id_regfile
  import titan_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o
);

  logic [NUM_REGS-1:0][XLEN-1:0] regs_q;
  logic [NUM_REGS-1:0][XLEN-1:0] regs_d;

  logic wr_live;
  assign wr_live = we_i && (waddr_i != '0);

  // NOTE: the default copy on the first line keeps every bit of regs_d
  // assigned on every path, so no latch is inferred.
  always_comb begin
    regs_d = regs_q;
    if (wr_live) regs_d[waddr_i] = wdata_i;
  end

  // NOTE: the array is reset because architectural state must start at zero;
  // this keeps it in flops rather than a RAM macro, which is fine at 32 words.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values; combinational blocks use blocking assignment.
  always_ff @(posedge clk_i) begin
    if (rst_i) regs_q <= '0;
    else       regs_q <= regs_d;
  end

  function automatic logic [XLEN-1:0] read_port(input logic [REG_AW-1:0] addr);
    logic [XLEN-1:0] val;
    val = (addr == '0) ? '0 : regs_q[addr];
    if (wr_live && (waddr_i == addr)) val = wdata_i;
    return val;
  endfunction

  assign rdata1_o = read_port(raddr1_i);
  assign rdata2_o = read_port(raddr2_i);

endmodule

// File: rtl/id_stage.sv
// ----------------------------------------------------------------------------
// id_stage
//   Instruction-decode stage of the Titan RV32I pipeline. Decodes the
//   instruction held in IF/ID, reads operands (with WB bypass), builds the
//   sign-extended immediate, detects load-use hazards and registers the
//   result into the ID/EX register. Flush, EX back-pressure and bubble
//   insertion are resolved here.
//
//   clk_i, rst_i                  clock, synchronous active-high reset
//   id_*_i                        IF/ID contents and valid (id_ready_i)
//   wb_we_i, wb_rd_i, wb_data_i   register-file write port from WB
//   ex_stall_i, flush_i           EX back-pressure and redirect kill
//   id_stall_o                    hold request to IF (combinational)
//   ex_*_o                        ID/EX pipeline register outputs
// ----------------------------------------------------------------------------
module id_stage
  import titan_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       id_instruction_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_pc_add4_i,
  input  logic              id_exc_addr_i,
  input  logic              id_ready_i,
  input  logic              wb_we_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]   wb_data_i,
  input  logic              ex_stall_i,
  input  logic              flush_i,
  output logic              id_stall_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_pc_add4_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output op_class_e         ex_op_o,
  output logic [2:0]        ex_funct3_o,
  output logic              ex_funct7b5_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_reg_write_o,
  output logic              ex_exc_illegal_o,
  output logic              ex_exc_addr_o
);

  // --------------------------------------------------------------------------
  // Instruction fields and immediates
  // --------------------------------------------------------------------------
  logic [31:0]       instr;
  logic [6:0]        opcode;
  logic [REG_AW-1:0] rs1, rs2, rd;

  assign instr  = id_instruction_i;
  assign opcode = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign rd     = instr[11:7];

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = sext({{20{instr[31]}}, instr[31:20]});
  assign imm_s = sext({{20{instr[31]}}, instr[31:25], instr[11:7]});
  assign imm_b = sext({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
  assign imm_u = sext({instr[31:12], 12'b0});
  assign imm_j = sext({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  op_class_e       dec_op;
  logic [XLEN-1:0] dec_imm;
  logic            dec_rs1_used, dec_rs2_used;
  logic            dec_mem_read, dec_mem_write, dec_reg_write, dec_illegal;

  always_comb begin
    dec_op        = OP_NONE;
    dec_imm       = '0;
    dec_rs1_used  = 1'b1;
    dec_rs2_used  = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_reg_write = 1'b0;
    dec_illegal   = 1'b0;
    if (instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode)
        OPC_LUI:    begin dec_op = OP_LUI;    dec_imm = imm_u; dec_rs1_used = 1'b0; dec_reg_write = 1'b1; end
        OPC_AUIPC:  begin dec_op = OP_AUIPC;  dec_imm = imm_u; dec_rs1_used = 1'b0; dec_reg_write = 1'b1; end
        OPC_JAL:    begin dec_op = OP_JAL;    dec_imm = imm_j; dec_rs1_used = 1'b0; dec_reg_write = 1'b1; end
        OPC_JALR:   begin dec_op = OP_JALR;   dec_imm = imm_i; dec_reg_write = 1'b1; end
        OPC_BRANCH: begin dec_op = OP_BRANCH; dec_imm = imm_b; dec_rs2_used = 1'b1; end
        OPC_LOAD:   begin dec_op = OP_LOAD;   dec_imm = imm_i; dec_mem_read = 1'b1; dec_reg_write = 1'b1; end
        OPC_STORE:  begin dec_op = OP_STORE;  dec_imm = imm_s; dec_rs2_used = 1'b1; dec_mem_write = 1'b1; end
        OPC_OPIMM:  begin dec_op = OP_OPIMM;  dec_imm = imm_i; dec_reg_write = 1'b1; end
        OPC_OP:     begin dec_op = OP_OP;     dec_rs2_used = 1'b1; dec_reg_write = 1'b1; end
        OPC_FENCE:  begin dec_op = OP_FENCE;  dec_imm = imm_i; end
        OPC_SYSTEM: begin dec_op = OP_SYSTEM; dec_imm = imm_i; end
        default:    dec_illegal = 1'b1;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Register file
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] rs1_data, rs2_data;

  id_regfile #(.XLEN(XLEN)) u_regfile (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .we_i     (wb_we_i),
    .waddr_i  (wb_rd_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_data),
    .rdata2_o (rs2_data)
  );

  // --------------------------------------------------------------------------
  // ID/EX register
  // --------------------------------------------------------------------------
  idex_ctrl_t        ctrl_q, ctrl_d, ctrl_live;
  logic [XLEN-1:0]   pc_q, pc_d, pc_add4_q, pc_add4_d;
  logic [XLEN-1:0]   rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]   imm_q, imm_d;
  logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              funct7b5_q, funct7b5_d;

  // A load in EX whose destination is read by the instruction in ID cannot
  // be forwarded in time; hold ID one cycle and send a bubble down.
  logic hazard;
  assign hazard = ctrl_q.valid & ctrl_q.mem_read & (rd_q != '0) & id_ready_i &
                  ((dec_rs1_used & (rs1 == rd_q)) | (dec_rs2_used & (rs2 == rd_q)));

  assign id_stall_o = ~rst_i & (hazard | ex_stall_i);

  // Control bundle for a normal load. A misaligned fetch must not write
  // architectural state, and an empty IF/ID slot carries no control at all.
  always_comb begin
    ctrl_live = '0;
    if (id_ready_i) begin
      ctrl_live.valid       = 1'b1;
      ctrl_live.op          = dec_op;
      ctrl_live.exc_illegal = dec_illegal;
      ctrl_live.exc_addr    = id_exc_addr_i;
      ctrl_live.mem_read    = dec_mem_read;
      ctrl_live.mem_write   = dec_mem_write & ~id_exc_addr_i;
      ctrl_live.reg_write   = dec_reg_write & ~id_exc_addr_i;
    end
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    pc_add4_d  = pc_add4_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    funct7b5_d = funct7b5_q;
    if (flush_i) begin
      ctrl_d = '0;
    end else if (!ex_stall_i) begin
      pc_d       = id_pc_i;
      pc_add4_d  = id_pc_add4_i;
      rs1_data_d = rs1_data;
      rs2_data_d = rs2_data;
      imm_d      = dec_imm;
      rs1_d      = rs1;
      rs2_d      = rs2;
      rd_d       = rd;
      funct3_d   = instr[14:12];
      funct7b5_d = instr[30];
      ctrl_d     = hazard ? '0 : ctrl_live;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      pc_q       <= RESET_PC;
      pc_add4_q  <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      funct7b5_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      pc_add4_q  <= pc_add4_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      funct3_q   <= funct3_d;
      funct7b5_q <= funct7b5_d;
    end
  end

  assign ex_valid_o       = ctrl_q.valid;
  assign ex_op_o          = ctrl_q.op;
  assign ex_mem_read_o    = ctrl_q.mem_read;
  assign ex_mem_write_o   = ctrl_q.mem_write;
  assign ex_reg_write_o   = ctrl_q.reg_write;
  assign ex_exc_illegal_o = ctrl_q.exc_illegal;
  assign ex_exc_addr_o    = ctrl_q.exc_addr;
  assign ex_pc_o          = pc_q;
  assign ex_pc_add4_o     = pc_add4_q;
  assign ex_rs1_data_o    = rs1_data_q;
  assign ex_rs2_data_o    = rs2_data_q;
  assign ex_imm_o         = imm_q;
  assign ex_rs1_o         = rs1_q;
  assign ex_rs2_o         = rs2_q;
  assign ex_rd_o          = rd_q;
  assign ex_funct3_o      = funct3_q;
  assign ex_funct7b5_o    = funct7b5_q;

endmodule
